// File: rtl/recorder_ctrl.sv
// recorder_ctrl: IDLE/RECORD/PLAY/PAUSE sequencer, speed control and SRAM address owner.
// Rev 1.0 -- optional LOOP_PLAY_EN: playback wraps to address 0 instead of returning to IDLE.
`default_nettype none

module recorder_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int MAX_RATIO = 7
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              key_stop,
  input  logic              key_faster,
  input  logic              key_slower,
  input  logic              interp_sel,
  input  logic              sample_tick,
  output logic [1:0]        state_o,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              sram_we,
  output logic [2:0]        ratio,
  output logic              speed_fast,
  output logic              isNormalSpeed,
  output logic              interp,
  output logic              pause,
  output logic              isRecord
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [2:0]        MAX_MAG   = 3'(MAX_RATIO);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_nx, end_nx;
  logic [2:0]        ratio_nx, ratio_spd;
  logic              fast_nx, fast_spd;
  logic [2:0]        sub, sub_nx, sub_adv;
  logic              speed_key;
  logic              slow_mode;
  logic [ADDR_W:0]   step;
  logic [ADDR_W:0]   sum;

  assign state_o = state;

  // Speed is a signed magnitude: a key first walks the magnitude toward zero,
  // then grows it in the key's own direction, saturating at MAX_MAG.
  always_comb begin
    ratio_spd = ratio;
    fast_spd  = speed_fast;
    if (key_faster) begin
      if (!speed_fast && ratio != 3'd0) begin
        ratio_spd = ratio - 3'd1;
      end else begin
        fast_spd  = 1'b1;
        ratio_spd = (ratio >= MAX_MAG) ? MAX_MAG : ratio + 3'd1;
      end
    end else if (key_slower) begin
      if (speed_fast && ratio != 3'd0) begin
        ratio_spd = ratio - 3'd1;
      end else begin
        fast_spd  = 1'b0;
        ratio_spd = (ratio >= MAX_MAG) ? MAX_MAG : ratio + 3'd1;
      end
    end
  end

  // Playback step per tick; sample-hold slow mode advances once per (ratio+1) ticks.
  always_comb begin
    slow_mode = !speed_fast && !isNormalSpeed;
    sub_adv   = sub;
    step      = '0;
    if (!slow_mode) begin
      step = (ADDR_W+1)'(ratio) + (ADDR_W+1)'(1);
    end else if (interp) begin
      step = (ADDR_W+1)'(1);
    end else if (sub == ratio) begin
      step    = (ADDR_W+1)'(1);
      sub_adv = 3'd0;
    end else begin
      sub_adv = sub + 3'd1;
    end
    sum = {1'b0, addr} + step;
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    end_nx    = end_addr;
    ratio_nx  = ratio;
    fast_nx   = speed_fast;
    sub_nx    = sub;
    speed_key = (state != S_RECORD) && (key_faster ^ key_slower);

    case (state)
      S_IDLE: begin
        if (key_play && end_addr != '0) begin
          state_nx = S_PLAY;
          addr_nx  = '0;
          sub_nx   = 3'd0;
        end else if (key_record) begin
          state_nx = S_RECORD;
          addr_nx  = '0;
        end
      end
      S_RECORD: begin
        if (key_stop) begin
          state_nx = S_IDLE;
          end_nx   = addr;
        end else if (sample_tick) begin
          if (addr == LAST_ADDR) begin
            state_nx = S_IDLE;
            end_nx   = addr;
          end else begin
            addr_nx = addr + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (key_stop) begin
          state_nx = S_IDLE;
          addr_nx  = '0;
        end else if (key_play) begin
          state_nx = S_PAUSE;
        end else if (sample_tick) begin
          sub_nx = sub_adv;
          if (sum >= {1'b0, end_addr}) begin
            addr_nx = '0;
`ifdef LOOP_PLAY_EN
            state_nx = S_PLAY;
`else
            state_nx = S_IDLE;
`endif
          end else begin
            addr_nx = sum[ADDR_W-1:0];
          end
        end
      end
      S_PAUSE: begin
        if (key_stop) begin
          state_nx = S_IDLE;
          addr_nx  = '0;
        end else if (key_play) begin
          state_nx = S_PLAY;
          sub_nx   = 3'd0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (speed_key) begin
      ratio_nx = ratio_spd;
      fast_nx  = fast_spd;
      sub_nx   = 3'd0;
    end
    // Recording always runs at normal speed, overriding any speed key this cycle.
    if (state == S_IDLE && state_nx == S_RECORD) begin
      ratio_nx = 3'd0;
      fast_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      end_addr      <= '0;
      ratio         <= 3'd0;
      speed_fast    <= 1'b1;
      isNormalSpeed <= 1'b1;
      interp        <= 1'b0;
      pause         <= 1'b0;
      isRecord      <= 1'b0;
      sram_we       <= 1'b0;
      sub           <= 3'd0;
    end else begin
      state         <= state_nx;
      addr          <= addr_nx;
      end_addr      <= end_nx;
      ratio         <= ratio_nx;
      speed_fast    <= fast_nx;
      isNormalSpeed <= (ratio_nx == 3'd0);
      interp        <= interp_sel;
      pause         <= (state_nx == S_PAUSE);
      isRecord      <= (state_nx == S_RECORD);
      sram_we       <= (state_nx == S_RECORD);
      sub           <= sub_nx;
    end
  end

endmodule

`default_nettype wire
